// File: rtl/bcd_serial_adder_ctrl_pkg.sv
// Shared constants and state encoding for the digit-serial BCD adder.
// Holds BCD digit width/limits and the controller FSM state type.
package bcd_serial_adder_ctrl_pkg;

   localparam int         BCD_W   = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_ADJ = 4'd6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal carry.
// Ports: a, b (BCD digits), cin -> s (BCD digit), cout (decimal carry).
module bcd_digit_add
   import bcd_serial_adder_ctrl_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [4:0] t;

   always_comb begin
      t    = {1'b0, a} + {1'b0, b} + {4'b0, cin};
      s    = t[3:0];
      cout = 1'b0;
      if (t > {1'b0, BCD_MAX}) begin
         // binary 10..19 -> decimal digit via +6, carry out of bit 3 dropped
         s    = t[3:0] + BCD_ADJ;
         cout = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial N-digit packed BCD adder, one digit pair per clock.
// Ports: clk, rst_n, start, a_in, b_in -> busy, done, sum, cout, err.
module bcd_serial_adder_ctrl
   import bcd_serial_adder_ctrl_pkg::*;
#(
   parameter int NDIGITS = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [4*NDIGITS-1:0]     a_in,
   input  logic [4*NDIGITS-1:0]     b_in,
   output logic                     busy,
   output logic                     done,
   output logic [4*NDIGITS-1:0]     sum,
   output logic                     cout,
   output logic                     err
);

   localparam int W  = BCD_W * NDIGITS;
   localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIGITS - 1);

   state_t state, nstate;

   logic [W-1:0]       a_sh, b_sh, sum_r;
   logic [CW-1:0]      cnt;
   logic               carry, cout_r, err_r;
   logic [NDIGITS-1:0] bad;
   logic               any_bad;
   logic [3:0]         dsum;
   logic               dcarry;
   logic [W+BCD_W-1:0] sum_cat;

   for (genvar i = 0; i < NDIGITS; i++) begin : g_chk
      assign bad[i] = (a_in[i*BCD_W +: BCD_W] > BCD_MAX)
                    | (b_in[i*BCD_W +: BCD_W] > BCD_MAX);
   end

   assign any_bad = |bad;

   bcd_digit_add u_dig (
      .s    (dsum),
      .cout (dcarry),
      .a    (a_sh[BCD_W-1:0]),
      .b    (b_sh[BCD_W-1:0]),
      .cin  (carry)
   );

   // new digit enters at the top; after NDIGITS shifts digit 0 is at [3:0]
   assign sum_cat = {dsum, sum_r};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         S_IDLE: if (start) nstate = any_bad ? S_DONE : S_ADD;
         S_ADD:  if (cnt == LAST) nstate = S_DONE;
         S_DONE: nstate = S_IDLE;
         default: nstate = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_r  <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  a_sh   <= a_in;
                  b_sh   <= b_in;
                  sum_r  <= '0;
                  cnt    <= '0;
                  carry  <= 1'b0;
                  cout_r <= 1'b0;
                  err_r  <= any_bad;
               end
            end
            S_ADD: begin
               sum_r <= sum_cat[W+BCD_W-1:BCD_W];
               carry <= dcarry;
               a_sh  <= a_sh >> BCD_W;
               b_sh  <= b_sh >> BCD_W;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) cout_r <= dcarry;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == S_ADD);
   assign done = (state == S_DONE);
   assign sum  = sum_r;
   assign cout = cout_r;
   assign err  = err_r;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed bench for the digit-serial BCD adder (4-digit and 1-digit builds).
// Drives after the rising edge and samples 1 time unit later.
module tb_bcd_serial_adder_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] a_in, b_in;
   logic        busy, done, cout, err;
   logic [15:0] sum;

   logic        start1;
   logic [3:0]  a1, b1;
   logic        busy1, done1, cout1, err1;
   logic [3:0]  sum1;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   bcd_serial_adder_ctrl #(.NDIGITS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a_in  (a_in),
      .b_in  (b_in),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .err   (err)
   );

   bcd_serial_adder_ctrl #(.NDIGITS(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start1),
      .a_in  (a1),
      .b_in  (b1),
      .busy  (busy1),
      .done  (done1),
      .sum   (sum1),
      .cout  (cout1),
      .err   (err1)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // rs: busy cycle on which to pulse a (to be ignored) second start
   // hold: keep start high during the done cycle (must be ignored)
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input int rs, input logic hold,
                         input int exp_edges, input int exp_busy,
                         input logic [15:0] exp_sum,
                         input logic exp_cout, input logic exp_err);
      int edges;
      int busyc;
      start = 1'b1;
      a_in  = a;
      b_in  = b;
      @(posedge clk); #1;
      start = 1'b0;
      edges = 1;
      busyc = 0;
      while (!done && edges < 30) begin
         if (busy) busyc++;
         if (busy && busyc == rs) begin
            start = 1'b1;
            a_in  = 16'h0001;
            b_in  = 16'h0001;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         edges++;
      end
      check("done_seen", 32'(done), 32'd1);
      check("latency", 32'(edges), 32'(exp_edges));
      check("busy_cycles", 32'(busyc), 32'(exp_busy));
      check("sum", 32'(sum), 32'(exp_sum));
      check("cout", 32'(cout), 32'(exp_cout));
      check("err", 32'(err), 32'(exp_err));
      start = hold;
      @(posedge clk); #1;
      start = 1'b0;
      check("done_pulse", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("sum_hold", 32'(sum), 32'(exp_sum));
      check("cout_hold", 32'(cout), 32'(exp_cout));
   endtask

   initial begin
      int edges;
      rst_n  = 1'b0;
      start  = 1'b0;
      a_in   = '0;
      b_in   = '0;
      start1 = 1'b0;
      a1     = '0;
      b1     = '0;
      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst1_sum", 32'(sum1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(16'h0045, 16'h0055, 0, 1'b0, 5, 4, 16'h0100, 1'b0, 1'b0);
      run_op(16'h12A4, 16'h0000, 0, 1'b0, 1, 0, 16'h0000, 1'b0, 1'b1);
      run_op(16'h9999, 16'h0001, 0, 1'b0, 5, 4, 16'h0000, 1'b1, 1'b0);
      run_op(16'h1234, 16'h8765, 0, 1'b0, 5, 4, 16'h9999, 1'b0, 1'b0);
      run_op(16'h5555, 16'h5555, 2, 1'b1, 5, 4, 16'h1110, 1'b1, 1'b0);

      // abort mid-operation after two digits
      start = 1'b1;
      a_in  = 16'h5555;
      b_in  = 16'h5555;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_sum", 32'(sum), 32'd0);
      check("arst_cout", 32'(cout), 32'd0);
      check("arst_err", 32'(err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(16'h0009, 16'h0009, 0, 1'b0, 5, 4, 16'h0018, 1'b0, 1'b0);

      // single-digit build
      start1 = 1'b1;
      a1     = 4'h7;
      b1     = 4'h8;
      @(posedge clk); #1;
      start1 = 1'b0;
      edges  = 1;
      while (!done1 && edges < 30) begin
         @(posedge clk); #1;
         edges++;
      end
      check("n1_done", 32'(done1), 32'd1);
      check("n1_latency", 32'(edges), 32'd2);
      check("n1_sum", 32'(sum1), 32'h5);
      check("n1_cout", 32'(cout1), 32'd1);
      check("n1_err", 32'(err1), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_serial_adder_ctrl.md
Name: bcd_serial_adder_ctrl

Overview:
Digit-serial multi-digit BCD adder controller. It captures two packed N-digit BCD operands on a start strobe and validates every digit. It then feeds one digit pair per clock, least-significant first, through a single combinational BCD digit-adder stage, registering the inter-digit carry. It assembles the packed N-digit BCD sum, the final carry-out and an invalid-operand flag, and reports completion with a one-cycle done pulse.

Parameters:
NDIGITS, 4, number of BCD digits per operand (legal range 1..8)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous and active-low
start  input  1  request; sampled only in IDLE
a_in  input  4*NDIGITS  operand A, packed BCD, digit 0 in bits [3:0]
b_in  input  4*NDIGITS  operand B, packed BCD, same packing
busy  output  1  high while an operation is in progress (LOAD accepted through last ADD cycle)
done  output  1  one-cycle pulse marking sum, cout and err valid
sum  output  4*NDIGITS  packed BCD result
cout  output  1  decimal carry out of the most significant digit
err  output  1  an operand digit was greater than 9

Behaviour:
- Interface fixed: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (assert at any time, including mid-operation):
  - state returns to IDLE immediately;
  - busy=0, done=0, sum=0, cout=0, err=0;
  - internal shift registers, digit counter and carry are cleared.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - Edge E0 with start=1: capture a_in/b_in into shift registers, clear carry, set digit counter to 0, clear sum, cout and err.
  - If any nibble of a_in or b_in is greater than 9: set err=1, sum=0, cout=0, go to DONE with no ADD cycles.
  - Otherwise go to ADD.
  - start=0: remain in IDLE; outputs hold their last values.
- ADD, edges E1..E(NDIGITS), one digit per edge:
  - Add the low nibbles of the A and B shift registers plus the registered carry via bcd_digit_add.
  - Shift the digit result into sum from the top, so after NDIGITS shifts digit 0 lands in [3:0].
  - Register the digit carry and shift both operand registers right by 4.
  - Increment the counter; after the edge where counter == NDIGITS-1, go to DONE and write cout from the digit carry.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE on the next edge.
  - start is ignored while in DONE.
- busy is 1 in ADD and 0 in IDLE and DONE.
- start asserted while busy or done is ignored; there is no queueing.
- Latency: done is high in the cycle after edge E(NDIGITS+1) sampled start, i.e. NDIGITS+1 edges after acceptance. On the err path this is 1 edge.
- sum, cout and err remain stable from done until the next accepted start.
- Digit-adder rule:
  - t = a + b + cin (5-bit);
  - if t > 9 then digit = t + 6 (mod 16) and carry = 1;
  - else digit = t and carry = 0.
- Maximum result 99..9 + 99..9 = 99..8 with cout=1. No saturation; cout is the overflow indicator.
- Back-to-back: start may be re-asserted in the IDLE cycle immediately after done; minimum issue interval is NDIGITS+2 cycles.

Decomposition:
- Shared constants header holds:
  - BCD_W = 4, BCD_MAX = 9, BCD_ADJ = 6;
  - state encodings S_IDLE = 2'd0, S_ADD = 2'd1, S_DONE = 2'd2.
- One sub-module, bcd_digit_add (purely combinational), with ports s[3:0], cout, a[3:0], b[3:0], cin. It is instanced once in the datapath.
- Digit validation is a generate loop over NDIGITS inside the top module.

Test Plan:
- NDIGITS=4, A=0x0045, B=0x0055, start pulse -> busy for 4 cycles; done pulse 5 edges after start; sum=0x0100, cout=0, err=0.
- A=0x9999, B=0x0001 -> sum=0x0000, cout=1; then A=0x1234, B=0x8765 back-to-back in the IDLE cycle after done -> sum=0x9999, cout=0.
- A=0x12A4, B=0x0000 -> no busy cycles; done one edge after start; err=1, sum=0, cout=0; the next valid operation clears err.
- Start A=0x5555, B=0x5555, pulse start again on the 2nd busy cycle with A=0x0001, B=0x0001 -> second request ignored; result sum=0x1110, cout=1.
- Assert rst_n low mid-ADD (after 2 digits) -> busy, done, sum and cout go to 0 asynchronously. After release, a new start with A=0x0009, B=0x0009 -> sum=0x0018, cout=0.
- NDIGITS=1 build, A=0x7, B=0x8 -> done 2 edges after start; sum=0x5, cout=1.
